// File: rtl/control.sv
`default_nettype none
// ============================================================================
// Module   : control
// Purpose  : Moore control FSM for the LC-3b multicycle datapath. Sequences
//            fetch / decode / execute for ADD, AND, NOT, BR, LDR and STR,
//            drives every datapath mux select, register load and ALU op, and
//            runs the memory request/response handshake.
// Ports    : clk            - system clock, rising-edge active
//            reset          - asynchronous active-high reset (to FETCH1)
//            opcode         - IR[15:12] from the datapath
//            branch_enable  - NZP compare result from the datapath
//            mem_resp       - memory completed current read/write
//            *_sel          - datapath mux selects
//            load_*         - datapath register load enables
//            aluop          - ALU operation (add/and/not/pass)
//            mem_read/write - memory request strobes
//            instret        - retired-instruction counter (optional)
// Options  : CONTROL_PERF_CNT_EN - adds the 32-bit instret counter/port.
// Revision : 1.0 - initial release
// ============================================================================
module control (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] opcode,
  input  logic       branch_enable,
  input  logic       mem_resp,
  output logic       pcmux_sel,
  output logic       storemux_sel,
  output logic       alumux_sel,
  output logic       marmux_sel,
  output logic       mdrmux_sel,
  output logic       regfilemux_sel,
  output logic       load_pc,
  output logic       load_cc,
  output logic       load_ir,
  output logic       load_mar,
  output logic       load_mdr,
  output logic       load_regfile,
  output logic [2:0] aluop,
  output logic       mem_read,
  output logic       mem_write
`ifdef CONTROL_PERF_CNT_EN
  ,
  output logic [31:0] instret
`endif
);

  // LC-3b opcode field encodings that this controller recognises
  localparam logic [3:0] OP_BR  = 4'b0000;
  localparam logic [3:0] OP_ADD = 4'b0001;
  localparam logic [3:0] OP_AND = 4'b0101;
  localparam logic [3:0] OP_LDR = 4'b0110;
  localparam logic [3:0] OP_STR = 4'b0111;
  localparam logic [3:0] OP_NOT = 4'b1001;

  // ALU operation encodings
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_AND  = 3'd1;
  localparam logic [2:0] ALU_NOT  = 3'd2;
  localparam logic [2:0] ALU_PASS = 3'd3;

  typedef enum logic [3:0] {
    FETCH1    = 4'd0,
    FETCH2    = 4'd1,
    FETCH3    = 4'd2,
    DECODE    = 4'd3,
    S_ADD     = 4'd4,
    S_AND     = 4'd5,
    S_NOT     = 4'd6,
    BR        = 4'd7,
    BR_TAKEN  = 4'd8,
    CALC_ADDR = 4'd9,
    LDR1      = 4'd10,
    LDR2      = 4'd11,
    STR1      = 4'd12,
    STR2      = 4'd13
  } state_t;

  state_t state_q, state_d;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= FETCH1;
    else       state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      FETCH1: state_d = FETCH2;
      FETCH2: if (mem_resp) state_d = FETCH3;
      FETCH3: state_d = DECODE;
      DECODE: begin
        case (opcode)
          OP_ADD:         state_d = S_ADD;
          OP_AND:         state_d = S_AND;
          OP_NOT:         state_d = S_NOT;
          OP_BR:          state_d = BR;
          OP_LDR, OP_STR: state_d = CALC_ADDR;
          default:        state_d = FETCH1;  // unsupported opcode runs as NOP
        endcase
      end
      S_ADD, S_AND, S_NOT: state_d = FETCH1;
      BR:        state_d = branch_enable ? BR_TAKEN : FETCH1;
      BR_TAKEN:  state_d = FETCH1;
      // opcode is still held in IR, so it selects load vs store here
      CALC_ADDR: state_d = (opcode == OP_LDR) ? LDR1 : STR1;
      LDR1:      if (mem_resp) state_d = LDR2;
      LDR2:      state_d = FETCH1;
      STR1:      state_d = STR2;
      STR2:      if (mem_resp) state_d = FETCH1;
      default:   state_d = FETCH1;
    endcase
  end

  // Moore output decode. Reset gates everything to zero combinationally so
  // memory strobes drop in the same cycle reset is raised.
  always_comb begin
    pcmux_sel      = 1'b0;
    storemux_sel   = 1'b0;
    alumux_sel     = 1'b0;
    marmux_sel     = 1'b0;
    mdrmux_sel     = 1'b0;
    regfilemux_sel = 1'b0;
    load_pc        = 1'b0;
    load_cc        = 1'b0;
    load_ir        = 1'b0;
    load_mar       = 1'b0;
    load_mdr       = 1'b0;
    load_regfile   = 1'b0;
    aluop          = ALU_ADD;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    if (!reset) begin
      unique case (state_q)
        FETCH1: begin
          marmux_sel = 1'b1;  // MAR <- PC
          load_mar   = 1'b1;
          load_pc    = 1'b1;  // PC <- PC + 2
        end
        FETCH2, LDR1: begin
          mem_read   = 1'b1;
          mdrmux_sel = 1'b1;
          load_mdr   = 1'b1;
        end
        FETCH3: load_ir = 1'b1;
        S_ADD, S_AND, S_NOT: begin
          load_regfile = 1'b1;
          load_cc      = 1'b1;
          if (state_q == S_AND)      aluop = ALU_AND;
          else if (state_q == S_NOT) aluop = ALU_NOT;
          else                       aluop = ALU_ADD;
        end
        BR_TAKEN: begin
          pcmux_sel = 1'b1;
          load_pc   = 1'b1;
        end
        CALC_ADDR: begin
          alumux_sel = 1'b1;  // base + offset6
          load_mar   = 1'b1;
        end
        LDR2: begin
          regfilemux_sel = 1'b1;
          load_regfile   = 1'b1;
          load_cc        = 1'b1;
        end
        STR1: begin
          storemux_sel = 1'b1;  // read SR onto the ALU A input
          aluop        = ALU_PASS;
          load_mdr     = 1'b1;
        end
        STR2: mem_write = 1'b1;
        default: ;
      endcase
    end
  end

`ifdef CONTROL_PERF_CNT_EN
  logic [31:0] instret_q;

  // Every instruction, legal or not, passes through DECODE exactly once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                 instret_q <= 32'd0;
    else if (state_q == DECODE) instret_q <= instret_q + 32'd1;
  end

  assign instret = instret_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_control
// Purpose  : Self-checking bench for the LC-3b control FSM. Directed table of
//            instructions, randomized instruction stream, and reset corners,
//            all compared cycle-by-cycle against an instruction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] opcode;
  logic       branch_enable;
  logic       mem_resp;
  logic       pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, regfilemux_sel;
  logic       load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile;
  logic [2:0] aluop;
  logic       mem_read, mem_write;
`ifdef CONTROL_PERF_CNT_EN
  logic [31:0] instret;
`endif

  control dut (
    .clk            (clk),
    .reset          (reset),
    .opcode         (opcode),
    .branch_enable  (branch_enable),
    .mem_resp       (mem_resp),
    .pcmux_sel      (pcmux_sel),
    .storemux_sel   (storemux_sel),
    .alumux_sel     (alumux_sel),
    .marmux_sel     (marmux_sel),
    .mdrmux_sel     (mdrmux_sel),
    .regfilemux_sel (regfilemux_sel),
    .load_pc        (load_pc),
    .load_cc        (load_cc),
    .load_ir        (load_ir),
    .load_mar       (load_mar),
    .load_mdr       (load_mdr),
    .load_regfile   (load_regfile),
    .aluop          (aluop),
    .mem_read       (mem_read),
    .mem_write      (mem_write)
`ifdef CONTROL_PERF_CNT_EN
    ,
    .instret        (instret)
`endif
  );

  always #5 clk = ~clk;

  // Output vector layout used for all comparisons
  localparam logic [16:0] M_PCMUX  = 17'd1 << 16;
  localparam logic [16:0] M_STMUX  = 17'd1 << 15;
  localparam logic [16:0] M_ALUMUX = 17'd1 << 14;
  localparam logic [16:0] M_MARMUX = 17'd1 << 13;
  localparam logic [16:0] M_MDRMUX = 17'd1 << 12;
  localparam logic [16:0] M_RFMUX  = 17'd1 << 11;
  localparam logic [16:0] M_LDPC   = 17'd1 << 10;
  localparam logic [16:0] M_LDCC   = 17'd1 << 9;
  localparam logic [16:0] M_LDIR   = 17'd1 << 8;
  localparam logic [16:0] M_LDMAR  = 17'd1 << 7;
  localparam logic [16:0] M_LDMDR  = 17'd1 << 6;
  localparam logic [16:0] M_LDRF   = 17'd1 << 5;
  localparam logic [16:0] M_RD     = 17'd1 << 4;
  localparam logic [16:0] M_WR     = 17'd1 << 3;
  localparam logic [16:0] A_ADD    = 17'd0;
  localparam logic [16:0] A_AND    = 17'd1;
  localparam logic [16:0] A_NOT    = 17'd2;
  localparam logic [16:0] A_PASS   = 17'd3;

  localparam logic [16:0] V_FETCH  = M_MARMUX | M_LDMAR | M_LDPC;
  localparam logic [16:0] V_READ   = M_RD | M_MDRMUX | M_LDMDR;

  int n_checks = 0;
  int n_errors = 0;
  int n_retired = 0;

  logic [16:0] exp_q[$];
  logic        resp_q[$];

  function automatic logic [16:0] act_vec();
    return {pcmux_sel, storemux_sel, alumux_sel, marmux_sel, mdrmux_sel, regfilemux_sel,
            load_pc, load_cc, load_ir, load_mar, load_mdr, load_regfile,
            mem_read, mem_write, aluop};
  endfunction

  task automatic check_vec(input string name, input int cyc, input logic [16:0] exp);
    logic [16:0] act;
    act = act_vec();
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s cycle %0d: outputs got %05h expected %05h", name, cyc, act, exp);
    end
  endtask

  task automatic check_instret(input string name, input int exp);
`ifdef CONTROL_PERF_CNT_EN
    n_checks++;
    if (instret !== 32'(exp)) begin
      n_errors++;
      $display("FAIL %s instret got %0d expected %0d", name, instret, exp);
    end
`endif
  endtask

  // One cycle with the given visible outputs; mem_resp is random unless the
  // cycle belongs to a memory phase.
  task automatic push(input logic [16:0] v, input logic resp);
    exp_q.push_back(v);
    resp_q.push_back(resp);
  endtask

  task automatic push_mem(input logic [16:0] v, input int waits);
    for (int w = 0; w < waits; w++) push(v, 1'b0);
    push(v, 1'b1);
  endtask

  // Instruction-level reference: the cycle-by-cycle output trace of one
  // complete instruction, built from what each phase of the instruction does.
  task automatic build_model(input logic [3:0] op, input logic br, input int fw, input int dw);
    exp_q.delete();
    resp_q.delete();
    push(V_FETCH, 1'($urandom_range(0, 1)));
    push_mem(V_READ, fw);
    push(M_LDIR, 1'($urandom_range(0, 1)));
    push(17'd0, 1'($urandom_range(0, 1)));  // decode
    case (op)
      4'b0001: push(M_LDRF | M_LDCC | A_ADD, 1'($urandom_range(0, 1)));
      4'b0101: push(M_LDRF | M_LDCC | A_AND, 1'($urandom_range(0, 1)));
      4'b1001: push(M_LDRF | M_LDCC | A_NOT, 1'($urandom_range(0, 1)));
      4'b0000: begin
        push(17'd0, 1'($urandom_range(0, 1)));
        if (br) push(M_PCMUX | M_LDPC, 1'($urandom_range(0, 1)));
      end
      4'b0110: begin
        push(M_ALUMUX | M_LDMAR | A_ADD, 1'($urandom_range(0, 1)));
        push_mem(V_READ, dw);
        push(M_RFMUX | M_LDRF | M_LDCC, 1'($urandom_range(0, 1)));
      end
      4'b0111: begin
        push(M_ALUMUX | M_LDMAR | A_ADD, 1'($urandom_range(0, 1)));
        push(M_STMUX | M_LDMDR | A_PASS, 1'($urandom_range(0, 1)));
        push_mem(M_WR, dw);
      end
      default: ;
    endcase
  endtask

  // Runs one instruction starting in its FETCH1 cycle (called in the first
  // half of that cycle) and returns in the first half of the next one.
  task automatic run_instr(input string name, input logic [3:0] op, input logic br,
                           input int fw, input int dw, input int lat);
    build_model(op, br, fw, dw);
    opcode = op;
    branch_enable = br;
    if (exp_q.size() != lat)
      $display("note: %s model length %0d vs table %0d", name, exp_q.size(), lat);
    for (int i = 0; i < exp_q.size(); i++) begin
      mem_resp = resp_q[i];
      @(negedge clk);
      check_vec(name, i, exp_q[i]);
      if (i == 0) check_instret(name, n_retired);
      @(posedge clk);
      #1;
    end
    n_retired++;
  endtask

  typedef struct {
    string      name;
    logic [3:0] op;
    logic       br;
    int         fw;
    int         dw;
    int         lat;
  } vec_t;

  vec_t tbl[11];

  initial begin
    tbl[0]  = '{"add",        4'b0001, 1'b0, 0, 0, 5};
    tbl[1]  = '{"and",        4'b0101, 1'b0, 0, 0, 5};
    tbl[2]  = '{"not",        4'b1001, 1'b0, 0, 0, 5};
    tbl[3]  = '{"br_nt",      4'b0000, 1'b0, 0, 0, 5};
    tbl[4]  = '{"br_t",       4'b0000, 1'b1, 0, 0, 6};
    tbl[5]  = '{"ldr_w3",     4'b0110, 1'b0, 0, 3, 10};
    tbl[6]  = '{"str",        4'b0111, 1'b0, 0, 0, 7};
    tbl[7]  = '{"str_w2",     4'b0111, 1'b1, 0, 2, 9};
    tbl[8]  = '{"illegal",    4'b1101, 1'b0, 0, 0, 4};
    tbl[9]  = '{"add_fw2",    4'b0001, 1'b0, 2, 0, 7};
    tbl[10] = '{"ldr_fw1w1",  4'b0110, 1'b1, 1, 1, 9};

    reset = 1'b1;
    mem_resp = 1'b1;
    opcode = 4'b0000;
    branch_enable = 1'b0;

    // Outputs held at zero throughout reset
    @(negedge clk);
    check_vec("reset_outputs", 0, 17'd0);
    check_instret("reset_outputs", 0);
    @(posedge clk);
    #1;
    reset = 1'b0;

    foreach (tbl[k])
      run_instr(tbl[k].name, tbl[k].op, tbl[k].br, tbl[k].fw, tbl[k].dw, tbl[k].lat);

    // Randomized instruction stream, including random mem_resp outside
    // memory phases (must be ignored)
    for (int n = 0; n < 300; n++) begin
      logic [3:0] op;
      logic       br;
      int         fw, dw;
      op = 4'($urandom_range(0, 15));
      br = 1'($urandom_range(0, 1));
      fw = $urandom_range(0, 3);
      dw = $urandom_range(0, 3);
      build_model(op, br, fw, dw);
      run_instr("random", op, br, fw, dw, exp_q.size());
    end

    // Reset raised during a FETCH2 wait state
    opcode = 4'b0001;
    mem_resp = 1'b0;
    @(negedge clk);
    check_vec("rst_fetch1", 0, V_FETCH);
    check_instret("rst_fetch1", n_retired);
    @(posedge clk);
    #1;
    mem_resp = 1'b0;
    @(negedge clk);
    check_vec("rst_fetch2_wait", 1, V_READ);
    #2;
    reset = 1'b1;
    #1;
    check_vec("rst_async_drop", 2, 17'd0);
    check_instret("rst_async_drop", 0);
    mem_resp = 1'b1;
    @(posedge clk);
    #1;
    check_vec("rst_held", 3, 17'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    n_retired = 0;
    run_instr("after_reset_add", 4'b0001, 1'b0, 0, 0, 5);
    run_instr("after_reset_ldr", 4'b0110, 1'b0, 0, 0, 7);

    // Final instruction start must be FETCH1
    @(negedge clk);
    check_vec("final_fetch1", 0, V_FETCH);
    check_instret("final_fetch1", n_retired);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // Global time bound so the bench always terminates
  initial begin
    #400000;
    $display("FAIL timeout: simulation time limit reached, checks %0d", n_checks);
    $fatal(1, "timeout");
  end

endmodule
`default_nettype wire
